exu_alu_mc_ctl: RTL and testbench
=================================

EXU_ALU_MC_CTL -- requirements
Module: exu_alu_mc_ctl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width (32 or 64).
REQ-002 The block SHALL have parameter BPC, default 4, bits processed per iteration cycle (power of 2, divides WIDTH).
REQ-003 The block SHALL have parameter CONST_B, default 3, constant addend for op ADDC.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all flops clock on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port freeze, input, 1, pipeline hold.
REQ-007 The block SHALL have port flush, input, 1, kill any in-flight or presented op.
REQ-008 The block SHALL have port in_valid, input, 1, op presented.
REQ-009 The block SHALL have port in_ready, output, 1, block can accept an op.
REQ-010 The block SHALL have port op, input, 4, opcode.
REQ-011 The block SHALL have port a, input, WIDTH, operand A.
REQ-012 The block SHALL have port b, input, WIDTH, operand B.
REQ-013 The block SHALL have port out_valid, output, 1, result valid pulse.
REQ-014 The block SHALL have port out, output, WIDTH, registered result.
REQ-015 The block SHALL have port busy, output, 1, high while an iterative op is in progress.

Function
REQ-016 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 ADDC (a+CONST_B, b ignored), 11 CPOP, 12 CLZ; 13-15 reserved, result 0.
REQ-017 Arithmetic SHALL be modulo 2^WIDTH; carry-out is discarded.
REQ-018 Shifts SHALL use b[log2(WIDTH)-1:0] only.
REQ-019 SLT/SLTU SHALL return 1 or 0, zero-extended to WIDTH.
REQ-020 The FSM SHALL have states IDLE and BUSY; busy = (state==BUSY).
REQ-021 in_ready SHALL equal (state==IDLE) & ~freeze.
REQ-022 An op SHALL be accepted when in_valid & in_ready & ~flush.
REQ-023 Ops 0-10 and 13-15: out and out_valid SHALL update on the edge that accepts the op (latency 1); out_valid is high for exactly one unfrozen cycle.
REQ-024 Ops 0-10 SHALL be accepted back-to-back every cycle.
REQ-025 CPOP/CLZ acceptance SHALL latch a, load the iteration counter to WIDTH/BPC, clear the accumulator and enter BUSY.
REQ-026 In BUSY, each unfrozen cycle SHALL consume BPC bits and decrement the counter.
REQ-027 CPOP SHALL consume LSB-first; CLZ SHALL consume MSB-first and stop accumulating after the first 1 found.
REQ-028 On the cycle the counter reaches 1, the next edge SHALL write out, pulse out_valid and return to IDLE.
REQ-029 Iterative latency SHALL be fixed at WIDTH/BPC+1 cycles from acceptance, independent of data.
REQ-030 A new op SHALL be acceptable in the cycle out_valid is high.
REQ-031 CLZ of 0 SHALL be WIDTH; CPOP of all-ones SHALL be WIDTH.
REQ-032 Freeze SHALL hold all state, out and out_valid unchanged.
REQ-033 Flush SHALL override freeze.
REQ-034 Flush SHALL force state IDLE and out_valid 0 on the next edge; out keeps its last value.
REQ-035 An op presented with flush high SHALL NOT be accepted.
REQ-036 out_valid SHALL be 0 in any cycle not following a completion.

Reset
REQ-037 While rst is high, state SHALL be IDLE, out_valid 0, out 0, counter 0, accumulator 0, busy 0, independent of clk.
REQ-038 Reset asserted mid-iteration SHALL abandon the op with no out_valid after release.
REQ-039 in_ready SHALL be 1 in the first cycle after rst deasserts, unless freeze is high.

Verification (WIDTH=32, BPC=4, CONST_B=3)
REQ-040 Bench SHALL cover: ADD a=0xFFFFFFFF b=1, then ADDC a=5, back-to-back -> out 0x0 then 0x8 on consecutive cycles, each with out_valid.
REQ-041 Bench SHALL cover: SLT and SLTU with a=1, b=0xFFFFFFFF -> 0 and 1; SRA a=0x80000000 b=0x21 -> 0xC0000000.
REQ-042 Bench SHALL cover: CPOP a=0xF0F0F0F1 -> busy 8 cycles, in_ready low 8 cycles, out 17, out_valid 9 cycles after accept.
REQ-043 Bench SHALL cover: CLZ a=0x00010000 -> 15; CLZ a=0 -> 32; each with latency 9.
REQ-044 Bench SHALL cover: flush in the 3rd BUSY cycle of CPOP -> no out_valid, in_ready 1 next cycle; freeze held 2 cycles during CLZ -> latency 11, result unchanged.
REQ-045 Bench SHALL cover: rst pulsed asynchronously mid-CPOP -> out 0, out_valid 0, busy 0 immediately, no later out_valid.

Source files
------------

// File: rtl/exu_alu_mc_ctl_if.sv
// ---------------------------------------------------------------------------
// exu_alu_mc_ctl_if
// Handshake and data bundle for the multi-cycle ALU controller.
//   master : the op issuer (pipeline front end / testbench)
//   slave  : the ALU controller
// Signals
//   freeze    - pipeline hold, every register in the ALU keeps its value
//   flush     - kill the in-flight or presented op
//   in_valid  - op presented this cycle
//   in_ready  - ALU can accept an op this cycle
//   op        - 4-bit opcode
//   a, b      - operands
//   out_valid - one-cycle result strobe
//   out       - registered result
//   busy      - an iterative op (CPOP/CLZ) is in progress
// ---------------------------------------------------------------------------
interface exu_alu_mc_ctl_if #(
   parameter int WIDTH = 32
);
   logic             freeze;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic [WIDTH-1:0] out;
   logic             busy;

   modport master (
      output freeze, flush, in_valid, op, a, b,
      input  in_ready, out_valid, out, busy
   );

   modport slave (
      input  freeze, flush, in_valid, op, a, b,
      output in_ready, out_valid, out, busy
   );
endinterface

// File: rtl/exu_alu_mc_ctl.sv
// ---------------------------------------------------------------------------
// exu_alu_mc_ctl
// ALU with single-cycle ops (ADD..ADDC, reserved) and iterative CPOP/CLZ.
// Single-cycle ops produce a registered result on the accepting edge and may
// issue back-to-back. CPOP/CLZ walk the operand BPC bits per cycle, so their
// latency is WIDTH/BPC+1 regardless of data.
// Ports
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - exu_alu_mc_ctl_if.slave (handshake, operands, result)
// ---------------------------------------------------------------------------
module exu_alu_mc_ctl #(
   parameter int WIDTH   = 32,
   parameter int BPC     = 4,
   parameter int CONST_B = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   exu_alu_mc_ctl_if.slave        bus
);

   localparam int NITER = WIDTH / BPC;
   localparam int CW    = $clog2(NITER) + 1;   // holds NITER itself
   localparam int AW    = $clog2(WIDTH) + 1;   // holds WIDTH itself
   localparam int SW    = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;
   localparam logic [3:0] OP_ADDC = 4'd10;
   localparam logic [3:0] OP_CPOP = 4'd11;
   localparam logic [3:0] OP_CLZ  = 4'd12;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] src_q, src_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             out_valid_q, out_valid_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic             found_q, found_d;     // CLZ: a 1 has already been seen
   logic             is_clz_q, is_clz_d;

   logic             in_ready;
   logic             accept;
   logic             iter_op;
   logic [SW-1:0]    shamt;
   logic [WIDTH-1:0] alu_res;

   logic [BPC-1:0]   lo_chunk;
   logic [BPC-1:0]   hi_chunk;
   logic [AW-1:0]    pop_chunk;
   logic [AW-1:0]    lz_chunk;
   logic [AW-1:0]    acc_step;

   assign in_ready = (state_q == IDLE) & ~bus.freeze;
   assign accept   = bus.in_valid & in_ready & ~bus.flush;
   assign iter_op  = (bus.op == OP_CPOP) | (bus.op == OP_CLZ);
   assign shamt    = bus.b[SW-1:0];

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out       = out_q;
   assign bus.busy      = (state_q == BUSY);

   // Single-cycle result
   always_comb begin
      alu_res = '0;
      case (bus.op)
         OP_ADD:  alu_res = bus.a + bus.b;
         OP_SUB:  alu_res = bus.a - bus.b;
         OP_AND:  alu_res = bus.a & bus.b;
         OP_OR:   alu_res = bus.a | bus.b;
         OP_XOR:  alu_res = bus.a ^ bus.b;
         OP_SLL:  alu_res = bus.a << shamt;
         OP_SRL:  alu_res = bus.a >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(bus.a) >>> shamt);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
         OP_ADDC: alu_res = bus.a + WIDTH'(CONST_B);
         default: alu_res = '0;
      endcase
   end

   // CPOP eats the low chunk (operand shifts right), CLZ eats the high chunk
   // (operand shifts left).
   assign lo_chunk = src_q[BPC-1:0];
   assign hi_chunk = src_q[WIDTH-1 -: BPC];

   always_comb begin
      pop_chunk = '0;
      for (int i = 0; i < BPC; i++) begin
         pop_chunk = pop_chunk + AW'(lo_chunk[i]);
      end
   end

   // Leading zeros within the chunk: scanning upward, the last set bit seen
   // is the most significant one. An all-zero chunk counts BPC.
   always_comb begin
      lz_chunk = AW'(BPC);
      for (int i = 0; i < BPC; i++) begin
         if (hi_chunk[i]) begin
            lz_chunk = AW'(BPC - 1 - i);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      found_d     = found_q;
      is_clz_d    = is_clz_q;
      acc_step    = acc_q;

      if (bus.flush) begin
         // Flush wins over freeze; out keeps its last value.
         state_d     = IDLE;
         out_valid_d = 1'b0;
         cnt_d       = '0;
      end else if (!bus.freeze) begin
         out_valid_d = 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (iter_op) begin
                     state_d  = BUSY;
                     src_d    = bus.a;
                     cnt_d    = CW'(NITER);
                     acc_d    = '0;
                     found_d  = 1'b0;
                     is_clz_d = (bus.op == OP_CLZ);
                  end else begin
                     out_d       = alu_res;
                     out_valid_d = 1'b1;
                  end
               end
            end
            BUSY: begin
               if (is_clz_q) begin
                  // Once a 1 is found the count is frozen, but the loop
                  // still runs to full length to keep latency fixed.
                  if (!found_q) begin
                     acc_step = acc_q + lz_chunk;
                  end
                  found_d = found_q | (|hi_chunk);
                  src_d   = src_q << BPC;
               end else begin
                  acc_step = acc_q + pop_chunk;
                  src_d    = src_q >> BPC;
               end
               acc_d = acc_step;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  out_d       = WIDTH'(acc_step);
                  out_valid_d = 1'b1;
                  state_d     = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         src_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
         acc_q       <= '0;
         found_q     <= 1'b0;
         is_clz_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         found_q     <= found_d;
         is_clz_q    <= is_clz_d;
      end
   end

endmodule

// File: tb/tb_exu_alu_mc_ctl.sv
// ---------------------------------------------------------------------------
// tb_exu_alu_mc_ctl
// Directed vectors for exu_alu_mc_ctl (WIDTH=32, BPC=4, CONST_B=3). The
// stimulus process pushes expected result + latency into a queue; the
// monitor pops on every out_valid and compares value and latency.
// ---------------------------------------------------------------------------
module tb_exu_alu_mc_ctl;

   typedef struct {
      logic [31:0] val;
      int          lat;
      int          pres;
      string       name;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   errors;
   exp_t sb[$];

   exu_alu_mc_ctl_if #(.WIDTH(32)) bus ();

   exu_alu_mc_ctl #(
      .WIDTH   (32),
      .BPC     (4),
      .CONST_B (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s act=0x%08h exp=0x%08h", nm, act, exp_v);
      end else begin
         $display("ok   %s 0x%08h", nm, act);
      end
   endtask

   // Monitor: one pop per observed result strobe.
   always @(negedge clk) begin
      if (!rst && bus.out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_out_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_out"}, bus.out, e.val);
            check({e.name, "_lat"}, 32'(cyc - e.pres), 32'(e.lat));
         end
      end
   end

   // Called at a negedge; returns at the next negedge with in_valid low.
   task automatic issue(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] exp_v, input int lat, input bit push,
                        input string nm);
      exp_t e;
      int   pres;
      bus.in_valid = 1'b1;
      bus.op       = o;
      bus.a        = aa;
      bus.b        = bb;
      pres         = cyc;
      #1;
      check({nm, "_ready"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      if (push) begin
         e.val  = exp_v;
         e.lat  = lat;
         e.pres = pres;
         e.name = nm;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_neg(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks       = 0;
      errors       = 0;
      rst          = 1'b1;
      bus.freeze   = 1'b0;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      bus.op       = 4'd0;
      bus.a        = '0;
      bus.b        = '0;

      // Reset state
      wait_neg(3);
      check("rst_out",       bus.out, 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy",      32'(bus.busy), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);

      // Back-to-back single-cycle ops
      issue(4'd0,  32'hFFFF_FFFF, 32'h1,         32'h0000_0000, 1, 1'b1, "add_wrap");
      issue(4'd10, 32'h5,         32'h1234,      32'h0000_0008, 1, 1'b1, "addc");
      issue(4'd1,  32'h5,         32'h7,         32'hFFFF_FFFE, 1, 1'b1, "sub");
      issue(4'd2,  32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 1, 1'b1, "and");
      issue(4'd3,  32'hF000_000F, 32'h0000_FF00, 32'hF000_FF0F, 1, 1'b1, "or");
      issue(4'd4,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1, 1'b1, "xor");
      issue(4'd5,  32'h1,         32'h24,        32'h0000_0010, 1, 1'b1, "sll");
      issue(4'd6,  32'h8000_0000, 32'h4,         32'h0800_0000, 1, 1'b1, "srl");
      issue(4'd7,  32'h8000_0000, 32'h21,        32'hC000_0000, 1, 1'b1, "sra");
      issue(4'd9,  32'h1,         32'hFFFF_FFFF, 32'h0000_0001, 1, 1'b1, "sltu");
      issue(4'd13, 32'h1234_5678, 32'h9,         32'h0000_0000, 1, 1'b1, "rsvd13");
      issue(4'd8,  32'h1,         32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b1, "slt");
      wait_neg(2);

      // CPOP: busy and not ready for 8 cycles, then an op in the out_valid cycle
      issue(4'd11, 32'hF0F0_F0F1, 32'h0, 32'd17, 9, 1'b1, "cpop");
      for (int k = 0; k < 8; k++) begin
         check($sformatf("cpop_busy%0d", k),  32'(bus.busy), 32'd1);
         check($sformatf("cpop_nrdy%0d", k),  32'(bus.in_ready), 32'd0);
         @(negedge clk);
      end
      check("cpop_done_busy", 32'(bus.busy), 32'd0);
      issue(4'd0, 32'h2, 32'h3, 32'd5, 1, 1'b1, "add_after_iter");
      wait_neg(2);

      // CLZ / CPOP boundaries
      issue(4'd12, 32'h0001_0000, 32'h0, 32'd15, 9, 1'b1, "clz_bit16");
      wait_neg(9);
      issue(4'd12, 32'h0000_0000, 32'h0, 32'd32, 9, 1'b1, "clz_zero");
      wait_neg(9);
      issue(4'd11, 32'hFFFF_FFFF, 32'h0, 32'd32, 9, 1'b1, "cpop_ones");
      wait_neg(9);

      // Flush in the 3rd busy cycle of CPOP: no result, ready next cycle
      issue(4'd11, 32'hF0F0_F0F1, 32'h0, 32'd17, 9, 1'b0, "cpop_flush");
      wait_neg(2);
      check("flush_busy_before", 32'(bus.busy), 32'd1);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      #1;
      check("flush_ready", 32'(bus.in_ready), 32'd1);
      check("flush_busy",  32'(bus.busy), 32'd0);
      check("flush_out_kept", bus.out, 32'd32);
      wait_neg(12);

      // Freeze 2 cycles during CLZ: latency stretches to 11
      issue(4'd12, 32'h0001_0000, 32'h0, 32'd15, 11, 1'b1, "clz_freeze");
      bus.freeze = 1'b1;
      wait_neg(2);
      bus.freeze = 1'b0;
      wait_neg(10);

      // Asynchronous reset mid-CPOP
      issue(4'd11, 32'hF0F0_F0F1, 32'h0, 32'd17, 9, 1'b0, "cpop_rst");
      wait_neg(2);
      #2;
      rst = 1'b1;
      #1;
      check("arst_out",       bus.out, 32'd0);
      check("arst_out_valid", 32'(bus.out_valid), 32'd0);
      check("arst_busy",      32'(bus.busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("arst_ready", 32'(bus.in_ready), 32'd1);
      wait_neg(12);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
